tdm_demux7: RTL and testbench

- Time-division demultiplexer: the receiving end of a 7-slot, one-bit-per-slot serial channel whose transmit side is a 3-bit-select 7:1 mux.
- Samples a serial bit stream on qualified strobes, aligns to a frame sync, and distributes slot i to parallel output bit i.
- Presents each completed frame on a latched 7-bit bus with a one-cycle valid pulse.
- Sits between a switch/mux-driven serial source and LEDR/HEX display logic on the DE1-SoC top level.

---
 rtl/tdm_demux7.sv | 124 ++++++++++++
 tb/tb_tdm_demux7.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux7.sv
// tdm_demux7 -- receive side of a 7-slot, one-bit-per-slot TDM serial link.
// Serial bits are sampled on en strobes and aligned to a slot-0 sync marker.
// Each completed frame appears on dout, together with a one-cycle frame_valid
// pulse and an increment of the wrapping frame counter.
// Build option: define TDM_STRICT_SYNC_EN to treat a strobe at slot 0 without
// sync as a lost lock. Otherwise the receiver flywheels through missing syncs.
module tdm_demux7 #(
  parameter int NSLOTS = 7,   // slots per frame, 2..8
  parameter int SEL_W  = 3,   // slot index width, 2**SEL_W >= NSLOTS
  parameter int CNT_W  = 8    // completed-frame counter width
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              en,
  input  logic              din,
  input  logic              sync,
  input  logic              clr_err,
  output logic [SEL_W-1:0]  slot,
  output logic [NSLOTS-1:0] dout,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err,
  output logic [CNT_W-1:0]  frames
);

  typedef enum logic {S_HUNT = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NSLOTS - 1);

  state_e              state_q;
  logic [SEL_W-1:0]    slot_q;
  logic [NSLOTS-1:0]   part_q;
  logic [NSLOTS-1:0]   dout_q;
  logic                fv_q;
  logic                locked_q;
  logic                err_q;
  logic [CNT_W-1:0]    frames_q;

  logic [NSLOTS-1:0]   part_d;   // partial frame with the current bit inserted
  logic [NSLOTS-1:0]   frame_d;  // finished frame when the last slot is sampled
  logic [NSLOTS-1:0]   first_d;  // fresh partial frame holding only slot 0

  // Build the candidate partial and completed frames from the current strobe.
  always_comb begin
    part_d         = part_q;
    part_d[slot_q] = din;
    frame_d        = {din, part_q[NSLOTS-2:0]};
    first_d        = '0;
    first_d[0]     = din;
  end

  // Main FSM. All outputs are registered. sync_err clear comes first, so a set
  // assigned later in the same edge overrides it.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_HUNT;
      slot_q   <= '0;
      part_q   <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      fv_q <= 1'b0;
      if (clr_err) err_q <= 1'b0;
      if (en) begin
        unique case (state_q)
          S_HUNT: begin
            // Only a sync strobe starts a frame. Everything else is dropped.
            if (sync) begin
              part_q   <= first_d;
              slot_q   <= SEL_W'(1);
              state_q  <= S_RUN;
              locked_q <= 1'b1;
            end
          end
          S_RUN: begin
            if (sync && (slot_q != '0)) begin
              // Sync arrived mid-frame. Restart the frame on this bit as slot 0.
              err_q  <= 1'b1;
              part_q <= first_d;
              slot_q <= SEL_W'(1);
            end
`ifdef TDM_STRICT_SYNC_EN
            else if (!sync && (slot_q == '0)) begin
              // Missing sync at slot 0: drop the bit and return to hunting.
              err_q    <= 1'b1;
              part_q   <= '0;
              slot_q   <= '0;
              state_q  <= S_HUNT;
              locked_q <= 1'b0;
            end
`endif
            else if (slot_q == LAST_SLOT) begin
              // Last slot: publish the frame and wrap to slot 0.
              part_q   <= part_d;
              dout_q   <= frame_d;
              fv_q     <= 1'b1;
              frames_q <= frames_q + CNT_W'(1);
              slot_q   <= '0;
            end else begin
              part_q <= part_d;
              slot_q <= slot_q + SEL_W'(1);
            end
          end
          default: begin
            state_q  <= S_HUNT;
            slot_q   <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign slot        = slot_q;
  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign locked      = locked_q;
  assign sync_err    = err_q;
  assign frames      = frames_q;

endmodule

// File: tb/tb_tdm_demux7.sv
// tb_tdm_demux7 -- self-checking bench for tdm_demux7.
// It applies a vector table for the first frame and uses task sequences for
// the multi-cycle cases. Completed frames go into a scoreboard queue, which a
// monitor drains and checks on every frame_valid pulse.
module tb_tdm_demux7;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       en       = 1'b0;
  logic       din      = 1'b0;
  logic       sync     = 1'b0;
  logic       clr_err  = 1'b0;
  logic [2:0] slot;
  logic [6:0] dout;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
  logic [7:0] frames;

  tdm_demux7 #(.NSLOTS(7), .SEL_W(3), .CNT_W(8)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .en          (en),
    .din         (din),
    .sync        (sync),
    .clr_err     (clr_err),
    .slot        (slot),
    .dout        (dout),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .frames      (frames)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [6:0] d;
    logic [7:0] f;
  } exp_t;

  typedef struct {
    logic       en, din, sync, clr;
    logic [2:0] slot;
    logic       lk, err, push;
    logic [6:0] dexp;
  } vec_t;

  exp_t       sbq[$];
  vec_t       tbl[10];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_frames = 8'd0;
  logic       prev_fv = 1'b0;
  logic       bb_mode = 1'b0;
  int         cyc = 0;
  int         last_pulse = 0;
  int         n_pulses = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [6:0] d);
    exp_t e;
    exp_frames = exp_frames + 8'd1;
    e.d = d;
    e.f = exp_frames;
    sbq.push_back(e);
  endtask

  task automatic step(input logic e, input logic d, input logic s, input logic c);
    @(negedge CLOCK_50);
    en = e; din = d; sync = s; clr_err = c;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_frame(input logic [6:0] bits, input logic s0, input int gap);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) push_exp(bits);
      step(1'b1, bits[i], (i == 0) && s0, 1'b0);
      chk("sf_slot", int'(slot), (i + 1) % 7);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'($urandom), 1'($urandom), 1'b0);
        chk("gap_slot", int'(slot), (i + 1) % 7);
      end
    end
  endtask

  // Scoreboard monitor: each frame_valid pulse must match the next queued
  // frame, must last one cycle, and must come every 7 cycles when frames run
  // back to back.
  always @(posedge CLOCK_50) begin
    #1;
    cyc++;
    if (resetn) begin
      if (frame_valid) begin
        exp_t e;
        n_pulses++;
        if (prev_fv) begin
          n_chk++; n_fail++;
          $display("FAIL fv_stretch: frame_valid high 2 cycles, expected 1 (t=%0t)", $time);
        end
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_fv: frame_valid=1, expected 0 (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          chk("sb_dout", int'(dout), int'(e.d));
          chk("sb_frames", int'(frames), int'(e.f));
        end
        if (bb_mode && last_pulse != 0) chk("fv_period", cyc - last_pulse, 7);
        last_pulse = cyc;
      end
    end
    prev_fv = frame_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] start_cnt;

    // Vector table for a single frame with din = 1,0,1,1,0,0,1, giving dout 7'h4D.
    //           en   din  sync clr  slot  lk   err  push dexp
    tbl[0] = '{1'b0,1'b1,1'b1,1'b0,3'd0,1'b0,1'b0,1'b0,7'h00}; // en=0 ignored
    tbl[1] = '{1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,7'h00}; // no sync: hunt
    tbl[2] = '{1'b1,1'b1,1'b1,1'b0,3'd1,1'b1,1'b0,1'b0,7'h00}; // slot0=1, lock
    tbl[3] = '{1'b1,1'b0,1'b0,1'b0,3'd2,1'b1,1'b0,1'b0,7'h00};
    tbl[4] = '{1'b1,1'b1,1'b0,1'b0,3'd3,1'b1,1'b0,1'b0,7'h00};
    tbl[5] = '{1'b0,1'b0,1'b1,1'b0,3'd3,1'b1,1'b0,1'b0,7'h00}; // gap holds
    tbl[6] = '{1'b1,1'b1,1'b0,1'b0,3'd4,1'b1,1'b0,1'b0,7'h00};
    tbl[7] = '{1'b1,1'b0,1'b0,1'b0,3'd5,1'b1,1'b0,1'b0,7'h00};
    tbl[8] = '{1'b1,1'b0,1'b0,1'b0,3'd6,1'b1,1'b0,1'b0,7'h00};
    tbl[9] = '{1'b1,1'b1,1'b0,1'b0,3'd0,1'b1,1'b0,1'b1,7'h4D}; // frame done

    // Reset state
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_slot", int'(slot), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(sync_err), 0);
    chk("rst_frames", int'(frames), 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;

    // Single frame from the vector table
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].push) push_exp(tbl[i].dexp);
      step(tbl[i].en, tbl[i].din, tbl[i].sync, tbl[i].clr);
      chk("tbl_slot", int'(slot), int'(tbl[i].slot));
      chk("tbl_locked", int'(locked), int'(tbl[i].lk));
      chk("tbl_err", int'(sync_err), int'(tbl[i].err));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_dout", int'(dout), 'h4D);
    chk("single_frames", int'(frames), 1);
    chk("single_fv_low", int'(frame_valid), 0);

    // Same frame with two idle cycles after every strobe
    send_frame(7'h4D, 1'b1, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_dout", int'(dout), 'h4D);
    chk("gap_frames", int'(frames), 2);

    // Misaligned sync at slot 3
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("mis_pre_slot", int'(slot), 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("mis_err", int'(sync_err), 1);
    chk("mis_slot", int'(slot), 1);
    chk("mis_dout", int'(dout), 'h4D);
    chk("mis_frames", int'(frames), 2);
    chk("mis_locked", int'(locked), 1);
    for (int i = 1; i < 7; i++) begin
      if (i == 6) push_exp(7'h7F);
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("mis_end_slot", int'(slot), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_err", int'(sync_err), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("reconfirm_err", int'(sync_err), 0);
    chk("reconfirm_slot", int'(slot), 1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("set_wins_err", int'(sync_err), 1);
    chk("set_wins_slot", int'(slot), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_err2", int'(sync_err), 0);
    for (int i = 1; i < 7; i++) begin
      if (i == 6) push_exp(7'h00);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Missing sync on the second frame
    send_frame(7'h2A, 1'b1, 0);
`ifdef TDM_STRICT_SYNC_EN
    begin
      logic [6:0] b;
      b = 7'h55;
      step(1'b1, b[0], 1'b0, 1'b0);
      chk("miss_err", int'(sync_err), 1);
      chk("miss_locked", int'(locked), 0);
      chk("miss_slot", int'(slot), 0);
      for (int i = 1; i < 7; i++) begin
        step(1'b1, b[i], 1'b0, 1'b0);
        chk("hunt_slot", int'(slot), 0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("miss_dout", int'(dout), 'h2A);
      chk("miss_frames", int'(frames), int'(exp_frames));
      chk("miss_clr", int'(sync_err), 0);
    end
`else
    send_frame(7'h55, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("fly_err", int'(sync_err), 0);
    chk("fly_locked", int'(locked), 1);
    chk("fly_dout", int'(dout), 'h55);
`endif

    // 256 back-to-back frames, so the counter wraps through zero
    start_cnt  = exp_frames;
    last_pulse = 0;
    n_pulses   = 0;
    bb_mode    = 1'b1;
    for (int f = 0; f < 256; f++) send_frame(7'($urandom), 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    bb_mode = 1'b0;
    chk("wrap_frames", int'(frames), int'(start_cnt));
    chk("wrap_pulses", n_pulses, 256);

    // Reset asserted mid-frame
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge CLOCK_50);
    en = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("mrst_dout", int'(dout), 0);
    chk("mrst_fv", int'(frame_valid), 0);
    chk("mrst_slot", int'(slot), 0);
    chk("mrst_locked", int'(locked), 0);
    chk("mrst_frames", int'(frames), 0);
    chk("mrst_err", int'(sync_err), 0);
    exp_frames = 8'd0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("post_rst_locked", int'(locked), 0);
      chk("post_rst_slot", int'(slot), 0);
    end
    send_frame(7'h33, 1'b1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_dout", int'(dout), 'h33);
    chk("post_rst_frames", int'(frames), 1);

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
